// File: rtl/window_stream_gen.sv
// Purpose : KxK sliding-window generator over a raster pixel stream with K-1 internal line buffers.
// Latency : 1 cycle from acceptance of an interior pixel to out_valid carrying its window.
// Backpr. : single output register; in_ready = !out_valid | out_ready, window held stable until taken.
// Build option WIN_COUNT_EN adds a saturating win_count output of handed-off windows.
module window_stream_gen #(
   parameter int PIX_W = 24,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int K     = 3
) (
   input  logic                       CLK100MHZ,
   input  logic                       CPU_RESETN,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_sof,
   input  logic [PIX_W-1:0]           in_pixel,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [K*K*PIX_W-1:0]       out_window,
   output logic [$clog2(IMG_W)-1:0]   out_x,
   output logic [$clog2(IMG_H)-1:0]   out_y,
`ifdef WIN_COUNT_EN
   output logic [31:0]                win_count,
`endif
   output logic                       frame_err
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int HALF = (K - 1) / 2;

   logic [XW-1:0]    col;
   logic [YW-1:0]    row;
   logic [XW-1:0]    eff_col;
   logic [YW-1:0]    eff_row;
   logic             accept;
   logic             emit;
   logic [PIX_W-1:0] line_mem [K-1][IMG_W];
   logic [PIX_W-1:0] win      [K][K];
   logic [PIX_W-1:0] win_nxt  [K][K];
   logic [K*K*PIX_W-1:0] win_flat;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A start-of-frame pixel is always treated as the frame origin, whatever the counters say.
   assign eff_col = in_sof ? '0 : col;
   assign eff_row = in_sof ? '0 : row;

   // Only centres whose full KxK neighbourhood lies inside the current frame produce a window.
   assign emit = (eff_row >= YW'(K - 1)) && (eff_col >= XW'(K - 1));

   // Next window: shift columns left, new right column is the vertical stack ending in the incoming pixel.
   always_comb begin
      win_nxt = win;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            win_nxt[r][c] = win[r][c+1];
         end
      end
      for (int r = 0; r < K - 1; r++) begin
         win_nxt[r][K-1] = line_mem[K-2-r][eff_col];
      end
      win_nxt[K-1][K-1] = in_pixel;
   end

   // Flatten the next window into the output bus layout, row 0 (oldest) first, column 0 leftmost.
   always_comb begin
      win_flat = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            win_flat[(r*K+c)*PIX_W +: PIX_W] = win_nxt[r][c];
         end
      end
   end

   // Line buffers cascade one row deeper per accepted pixel; contents need no reset.
   always_ff @(posedge CLK100MHZ) begin
      if (accept) begin
         line_mem[0][eff_col] <= in_pixel;
         for (int i = 1; i < K - 1; i++) begin
            line_mem[i][eff_col] <= line_mem[i-1][eff_col];
         end
      end
   end

   // Raster counters, shift window, output register and sof error pulse.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         col        <= '0;
         row        <= '0;
         out_valid  <= 1'b0;
         out_window <= '0;
         out_x      <= '0;
         out_y      <= '0;
         frame_err  <= 1'b0;
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win[r][c] <= '0;
            end
         end
      end else begin
         frame_err <= accept && in_sof && ((col != '0) || (row != '0));
         if (accept) begin
            win <= win_nxt;
            if (eff_col == XW'(IMG_W - 1)) begin
               col <= '0;
               row <= (eff_row == YW'(IMG_H - 1)) ? '0 : eff_row + 1'b1;
            end else begin
               col <= eff_col + 1'b1;
               row <= eff_row;
            end
         end
         if (accept && emit) begin
            out_valid  <= 1'b1;
            out_window <= win_flat;
            out_x      <= eff_col - XW'(HALF);
            out_y      <= eff_row - YW'(HALF);
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

`ifdef WIN_COUNT_EN
   // Count windows handed downstream; a new frame restarts the count, and it never wraps.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         win_count <= '0;
      end else if (accept && in_sof) begin
         win_count <= '0;
      end else if (out_valid && out_ready && (win_count != 32'hFFFF_FFFF)) begin
         win_count <= win_count + 32'd1;
      end
   end
`endif

endmodule
